// File: rtl/accum_frame_pkg.sv
// Shared definitions for the frame accumulator: FSM state encoding and the
// beat-count width/saturation constant. Operand width (M) and the carry-select
// block width (N) stay as module parameters.
package accum_frame_pkg;

   // Beat-count width and its saturation value.
   localparam int unsigned CntW = 8;
   localparam logic [CntW-1:0] CntMax = {CntW{1'b1}};

   // ACCUM: accepting operand beats. HOLD: presenting a frame result.
   typedef enum logic [0:0] {
      StAccum = 1'b0,
      StHold  = 1'b1
   } state_e;

endpackage

// File: rtl/CSelectA_M_N.sv
// Unsigned carry-select adder.
// Ports:
//   a, b  [M-1:0]  operands
//   cin            carry into the least significant block
//   sum   [M-1:0]  a + b + cin modulo 2^M
//   cout           carry out of the most significant block
// M must be a multiple of N. Each N-bit block precomputes its sum for both
// possible carry-ins; the incoming block carry only drives the selection muxes.
module CSelectA_M_N #(
   parameter int unsigned M = 16,
   parameter int unsigned N = 4
) (
   input  logic [M-1:0] a,
   input  logic [M-1:0] b,
   input  logic         cin,
   output logic [M-1:0] sum,
   output logic         cout
);

   localparam int unsigned NB = M / N;

   // c[k] is the carry into block k.
   logic [NB:0] c;

   assign c[0] = cin;

   for (genvar g = 0; g < NB; g++) begin : g_blk
      logic [N:0] s0;
      logic [N:0] s1;

      assign s0 = {1'b0, a[g*N +: N]} + {1'b0, b[g*N +: N]};
      assign s1 = {1'b0, a[g*N +: N]} + {1'b0, b[g*N +: N]} + {{N{1'b0}}, 1'b1};

      assign sum[g*N +: N] = c[g] ? s1[N-1:0] : s0[N-1:0];
      assign c[g+1]        = c[g] ? s1[N]     : s0[N];
   end

   assign cout = c[NB];

endmodule

// File: rtl/accum_frame.sv
// Frame accumulator: sums unsigned operand beats until a beat marked in_last,
// then presents the frame sum, a sticky carry-out flag and a saturating beat
// count on a valid/ready output until the consumer takes it.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   clear                synchronous frame abort (drops partial and pending results)
//   in_valid/in_ready    operand handshake; in_data [M-1:0], in_last
//   out_valid/out_ready  result handshake
//   out_sum [M-1:0]      frame sum modulo 2^M
//   out_ovf              any adder carry-out during the frame
//   out_count [7:0]      beats in the frame, saturating at 255
// Result fields keep their last loaded value while out_valid is low.
module accum_frame
   import accum_frame_pkg::*;
#(
   parameter int unsigned M = 16,
   parameter int unsigned N = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clear,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [M-1:0]    in_data,
   input  logic            in_last,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [M-1:0]    out_sum,
   output logic            out_ovf,
   output logic [CntW-1:0] out_count
);

   state_e          state_q, state_d;
   logic [M-1:0]    acc_q, acc_d;
   logic            ovf_q, ovf_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [M-1:0]    res_sum_q, res_sum_d;
   logic            res_ovf_q, res_ovf_d;
   logic [CntW-1:0] res_cnt_q, res_cnt_d;

   logic            accept;
   logic [M-1:0]    add_sum;
   logic            add_cout;
   logic [CntW-1:0] cnt_inc;

   CSelectA_M_N #(
      .M (M),
      .N (N)
   ) u_add (
      .a    (acc_q),
      .b    (in_data),
      .cin  (1'b0),
      .sum  (add_sum),
      .cout (add_cout)
   );

   // Handshake outputs depend on state only.
   assign in_ready  = (state_q == StAccum);
   assign out_valid = (state_q == StHold);
   assign accept    = in_valid & in_ready;

   assign cnt_inc = (cnt_q == CntMax) ? CntMax : cnt_q + {{(CntW-1){1'b0}}, 1'b1};

   assign out_sum   = res_sum_q;
   assign out_ovf   = res_ovf_q;
   assign out_count = res_cnt_q;

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      ovf_d     = ovf_q;
      cnt_d     = cnt_q;
      res_sum_d = res_sum_q;
      res_ovf_d = res_ovf_q;
      res_cnt_d = res_cnt_q;

      if (clear) begin
         // Abort wins over both handshakes; result registers are left as-is and
         // are simply no longer qualified by out_valid.
         state_d = StAccum;
         acc_d   = '0;
         ovf_d   = 1'b0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            StAccum: begin
               if (accept) begin
                  acc_d = add_sum;
                  ovf_d = ovf_q | add_cout;
                  cnt_d = cnt_inc;
                  if (in_last) begin
                     res_sum_d = add_sum;
                     res_ovf_d = ovf_q | add_cout;
                     res_cnt_d = cnt_inc;
                     state_d   = StHold;
                  end
               end
            end
            StHold: begin
               if (out_ready) begin
                  state_d = StAccum;
                  acc_d   = '0;
                  ovf_d   = 1'b0;
                  cnt_d   = '0;
               end
            end
            default: begin
               state_d = StAccum;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StAccum;
         acc_q     <= '0;
         ovf_q     <= 1'b0;
         cnt_q     <= '0;
         res_sum_q <= '0;
         res_ovf_q <= 1'b0;
         res_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         ovf_q     <= ovf_d;
         cnt_q     <= cnt_d;
         res_sum_q <= res_sum_d;
         res_ovf_q <= res_ovf_d;
         res_cnt_q <= res_cnt_d;
      end
   end

endmodule

// File: tb/tb_accum_frame.sv
// Scoreboard bench for accum_frame (M=16, N=4): the stimulus process pushes the
// hand-computed frame result when it issues a frame; a monitor pops and
// compares whenever an output handshake is about to complete.
module tb_accum_frame;

   localparam int unsigned M = 16;
   localparam int unsigned N = 4;

   typedef struct packed {
      logic [M-1:0] sum;
      logic         ovf;
      logic [7:0]   cnt;
   } exp_t;

   logic         clk;
   logic         rst_n;
   logic         clear;
   logic         in_valid;
   logic         in_ready;
   logic [M-1:0] in_data;
   logic         in_last;
   logic         out_valid;
   logic         out_ready;
   logic [M-1:0] out_sum;
   logic         out_ovf;
   logic [7:0]   out_count;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;

   accum_frame #(
      .M (M),
      .N (N)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_ovf   (out_ovf),
      .out_count (out_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: out_valid & out_ready at the falling edge means the handshake
   // completes on the next rising edge.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (q.size() == 0) begin
            chk("unexpected_result", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("out_sum", {16'd0, out_sum}, {16'd0, e.sum});
            chk("out_ovf", {31'd0, out_ovf}, {31'd0, e.ovf});
            chk("out_count", {24'd0, out_count}, {24'd0, e.cnt});
         end
      end
   end

   // Drive one beat and hold it until accepted; returns #1 after the accept edge.
   task automatic beat(input logic [M-1:0] d, input logic l);
      int t;
      t = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      @(negedge clk);
      while (!in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) chk("beat_timeout", 32'd1, 32'd0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = '0;
   endtask

   task automatic push(input logic [M-1:0] s, input logic o, input logic [7:0] c);
      exp_t e;
      e.sum = s;
      e.ovf = o;
      e.cnt = c;
      q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((q.size() != 0 || out_valid) && t < 100) begin
         tick();
         t++;
      end
      chk("drain", {31'd0, out_valid}, 32'd0);
   endtask

   initial begin
      rst_n     = 1'b0;
      clear     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      #12;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_sum", {16'd0, out_sum}, 32'd0);
      chk("rst_out_count", {24'd0, out_count}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

      // 1 + 2 + 3, valid for exactly one cycle after the last accept.
      push(16'h0006, 1'b0, 8'd3);
      beat(16'h0001, 1'b0);
      beat(16'h0002, 1'b0);
      beat(16'h0003, 1'b1);
      chk("valid_after_last", {31'd0, out_valid}, 32'd1);
      chk("ready_in_hold", {31'd0, in_ready}, 32'd0);
      tick();
      chk("valid_one_cycle", {31'd0, out_valid}, 32'd0);
      chk("ready_after_hs", {31'd0, in_ready}, 32'd1);

      // Carry out of the top block.
      push(16'h0001, 1'b1, 8'd2);
      beat(16'hFFFF, 1'b0);
      beat(16'h0002, 1'b1);
      drain();

      // Back-pressure: result stable and input stalled.
      out_ready = 1'b0;
      push(16'h1234, 1'b0, 8'd1);
      beat(16'h1234, 1'b1);
      for (int i = 0; i < 5; i++) begin
         chk("stall_sum", {16'd0, out_sum}, 32'h1234);
         chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
         chk("stall_valid", {31'd0, out_valid}, 32'd1);
         tick();
      end
      out_ready = 1'b1;
      push(16'h0005, 1'b0, 8'd1);
      beat(16'h0005, 1'b1);
      drain();

      // Clear mid-frame drops the partial sum.
      beat(16'h0010, 1'b0);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      push(16'h0020, 1'b0, 8'd1);
      beat(16'h0020, 1'b1);
      drain();

      // Clear in HOLD discards the pending result.
      out_ready = 1'b0;
      beat(16'h0077, 1'b1);
      chk("hold_before_clear", {31'd0, out_valid}, 32'd1);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("clear_valid", {31'd0, out_valid}, 32'd0);
      chk("clear_in_ready", {31'd0, in_ready}, 32'd1);
      out_ready = 1'b1;
      push(16'h0009, 1'b0, 8'd1);
      beat(16'h0009, 1'b1);
      drain();

      // Count saturation; sum keeps accumulating.
      push(16'h012C, 1'b0, 8'd255);
      for (int i = 0; i < 300; i++) begin
         beat(16'h0001, (i == 299));
      end
      drain();

      // Asynchronous reset while in HOLD.
      out_ready = 1'b0;
      beat(16'hABCD, 1'b1);
      chk("pre_reset_valid", {31'd0, out_valid}, 32'd1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("reset_valid", {31'd0, out_valid}, 32'd0);
      chk("reset_sum", {16'd0, out_sum}, 32'd0);
      chk("reset_ovf", {31'd0, out_ovf}, 32'd0);
      chk("reset_count", {24'd0, out_count}, 32'd0);
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      tick();
      chk("post_reset_in_ready", {31'd0, in_ready}, 32'd1);
      chk("post_reset_valid", {31'd0, out_valid}, 32'd0);

      // A frame after reset starts from zero.
      push(16'h0003, 1'b0, 8'd2);
      beat(16'h0001, 1'b0);
      beat(16'h0002, 1'b1);
      drain();

      chk("queue_empty", q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Backstop so the run always ends.
   initial begin
      #200000;
      $display("FAIL global_timeout: got timeout expected finish");
      $fatal(1);
   end

endmodule
